// File: rtl/spi_framer_pkg.sv
// Shared constants, codes and FSM encoding for the SPI command framer.
package spi_framer_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_HDR   = 2'b01,
    ERR_CHK   = 2'b10,
    ERR_ABORT = 2'b11
  } err_t;

  typedef enum logic [1:0] {
    OP_FUNC = 2'b00,
    OP_A    = 2'b01,
    OP_B    = 2'b10,
    OP_RD   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CMD  = 2'b01,
    ST_DATA = 2'b10,
    ST_CHK  = 2'b11
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_cmd_framer_if.sv
// Byte-receive and configuration-strobe bundle around the SPI command framer.
interface spi_cmd_framer_if;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       ss_active;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_data;
  logic       rd_strobe;
  logic [7:0] status_byte;
  logic [7:0] err_cnt;

  modport slave (
    input  rx_valid, rx_byte, ss_active,
    output cfg_we, cfg_sel, cfg_data, rd_strobe, status_byte, err_cnt
  );

  modport master (
    output rx_valid, rx_byte, ss_active,
    input  cfg_we, cfg_sel, cfg_data, rd_strobe, status_byte, err_cnt
  );
endinterface

// File: rtl/spi_frame_timer.sv
// Clearable inter-byte timeout counter; expired pulses in the cycle the limit is held.
module spi_frame_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign expired = en && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n || clr || expired) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_cmd_framer.sv
// SPI command framer: HDR/CMD/DATA[/CHK] frames to config strobes and status.
// Define SPI_FRAMER_CHKSUM_EN for the 4-byte checksummed frame; default is 3-byte.
module spi_cmd_framer
  import spi_framer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  spi_cmd_framer_if.slave   bus
);

  state_t     state_q, state_d;
  op_t        op_q;
  logic       commit, err_fire, lat_cmd, expired, busy;
  err_t       err_code, last_err;
  logic [7:0] commit_data;
  logic       cfg_we_q, rd_strobe_q;
  logic [1:0] cfg_sel_q;
  logic [7:0] cfg_data_q, err_cnt_q;
  logic [4:0] frame_cnt;

`ifdef SPI_FRAMER_CHKSUM_EN
  logic       lat_data;
  logic [7:0] data_q, chk_q;
  assign commit_data = data_q;
`else
  assign commit_data = bus.rx_byte;
`endif

  assign busy = (state_q != ST_IDLE);

  spi_frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (bus.rx_valid || !busy),
    .en      (busy),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    commit   = 1'b0;
    err_fire = 1'b0;
    err_code = ERR_NONE;
    lat_cmd  = 1'b0;
`ifdef SPI_FRAMER_CHKSUM_EN
    lat_data = 1'b0;
`endif
    // Abort outranks any byte arriving in the same cycle.
    if (busy && (!bus.ss_active || expired)) begin
      state_d  = ST_IDLE;
      err_fire = 1'b1;
      err_code = ERR_ABORT;
    end else if (bus.rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.ss_active) begin
            if (bus.rx_byte == HDR_BYTE) begin
              state_d = ST_CMD;
            end else begin
              err_fire = 1'b1;
              err_code = ERR_HDR;
            end
          end
        end
        ST_CMD: begin
          lat_cmd = 1'b1;
          state_d = ST_DATA;
        end
        ST_DATA: begin
`ifdef SPI_FRAMER_CHKSUM_EN
          lat_data = 1'b1;
          state_d  = ST_CHK;
`else
          commit   = 1'b1;
          state_d  = ST_IDLE;
`endif
        end
        default: begin
`ifdef SPI_FRAMER_CHKSUM_EN
          if (chk_q == bus.rx_byte) begin
            commit = 1'b1;
          end else begin
            err_fire = 1'b1;
            err_code = ERR_CHK;
          end
`endif
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_FUNC;
      cfg_we_q    <= 1'b0;
      rd_strobe_q <= 1'b0;
      cfg_sel_q   <= 2'b00;
      cfg_data_q  <= 8'h00;
      last_err    <= ERR_NONE;
      frame_cnt   <= 5'd0;
      err_cnt_q   <= 8'h00;
`ifdef SPI_FRAMER_CHKSUM_EN
      data_q      <= 8'h00;
      chk_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      cfg_we_q    <= commit && (op_q != OP_RD);
      rd_strobe_q <= commit && (op_q == OP_RD);
      if (lat_cmd) op_q <= op_t'(bus.rx_byte[7:6]);
`ifdef SPI_FRAMER_CHKSUM_EN
      // Running XOR so only the final compare is needed in CHK.
      if (lat_cmd)  chk_q <= HDR_BYTE ^ bus.rx_byte;
      if (lat_data) begin
        data_q <= bus.rx_byte;
        chk_q  <= chk_q ^ bus.rx_byte;
      end
`endif
      if (commit) begin
        if (op_q != OP_RD) begin
          cfg_sel_q  <= op_q;
          cfg_data_q <= commit_data;
        end
        frame_cnt <= frame_cnt + 5'd1;
        last_err  <= ERR_NONE;
      end
      if (err_fire) begin
        last_err  <= err_code;
        err_cnt_q <= sat_inc8(err_cnt_q);
      end
    end
  end

  assign bus.cfg_we      = cfg_we_q;
  assign bus.rd_strobe   = rd_strobe_q;
  assign bus.cfg_sel     = cfg_sel_q;
  assign bus.cfg_data    = cfg_data_q;
  assign bus.status_byte = {busy, last_err, frame_cnt};
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_spi_cmd_framer.sv
// Directed bench for spi_cmd_framer; expectations follow the SPI_FRAMER_CHKSUM_EN build.
module tb_spi_cmd_framer;

  localparam int TO = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   we_cnt = 0;
  int   rd_cnt = 0;

  spi_cmd_framer_if bus();

  spi_cmd_framer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.cfg_we === 1'b1)    we_cnt++;
    if (bus.rd_strobe === 1'b1) rd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] chk;
    chk = 8'hA5 ^ cmd ^ data;
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(data);
`ifdef SPI_FRAMER_CHKSUM_EN
    send_byte(chk);
`endif
  endtask

  task automatic test_reset();
    bus.ss_active = 1'b0;
    bus.rx_byte   = 8'h00;
    do_reset();
    total++; if (bus.cfg_we !== 1'b0) begin bad++; $display("FAIL reset_cfg_we got=%b exp=0", bus.cfg_we); end
    total++; if (bus.rd_strobe !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b exp=0", bus.rd_strobe); end
    total++; if (bus.cfg_sel !== 2'b00) begin bad++; $display("FAIL reset_sel got=%b exp=00", bus.cfg_sel); end
    total++; if (bus.cfg_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus.cfg_data); end
    total++; if (bus.status_byte !== 8'h00) begin bad++; $display("FAIL reset_status got=%h exp=00", bus.status_byte); end
    total++; if (bus.err_cnt !== 8'h00) begin bad++; $display("FAIL reset_errcnt got=%h exp=00", bus.err_cnt); end
  endtask

  task automatic test_write();
    do_reset();
    bus.ss_active = 1'b1;
    send_frame(8'h40, 8'h03);
    total++; if (bus.cfg_we !== 1'b1) begin bad++; $display("FAIL wr_we got=%b exp=1", bus.cfg_we); end
    total++; if (bus.rd_strobe !== 1'b0) begin bad++; $display("FAIL wr_rd got=%b exp=0", bus.rd_strobe); end
    total++; if (bus.cfg_sel !== 2'b01) begin bad++; $display("FAIL wr_sel got=%b exp=01", bus.cfg_sel); end
    total++; if (bus.cfg_data !== 8'h03) begin bad++; $display("FAIL wr_data got=%h exp=03", bus.cfg_data); end
    total++; if (bus.status_byte !== 8'h01) begin bad++; $display("FAIL wr_status got=%h exp=01", bus.status_byte); end
    tick();
    total++; if (bus.cfg_we !== 1'b0) begin bad++; $display("FAIL wr_we_pulse got=%b exp=0", bus.cfg_we); end
    total++; if ({bus.cfg_sel, bus.cfg_data} !== {2'b01, 8'h03}) begin bad++; $display("FAIL wr_hold got=%b/%h exp=01/03", bus.cfg_sel, bus.cfg_data); end
  endtask

  task automatic test_bad_chk();
    int we0;
    do_reset();
    we0 = we_cnt;
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h03); send_byte(8'h00);
    tick();
`ifdef SPI_FRAMER_CHKSUM_EN
    total++; if (bus.status_byte !== 8'h40) begin bad++; $display("FAIL chk_status got=%h exp=40", bus.status_byte); end
    total++; if (we_cnt != we0) begin bad++; $display("FAIL chk_nostrobe got=%0d exp=%0d", we_cnt, we0); end
`else
    total++; if (bus.status_byte !== 8'h21) begin bad++; $display("FAIL chk_status got=%h exp=21", bus.status_byte); end
    total++; if (we_cnt != we0 + 1) begin bad++; $display("FAIL chk_strobe got=%0d exp=%0d", we_cnt, we0 + 1); end
`endif
    total++; if (bus.err_cnt !== 8'd1) begin bad++; $display("FAIL chk_errcnt got=%0d exp=1", bus.err_cnt); end
    send_frame(8'h00, 8'h02);
    total++; if (bus.cfg_we !== 1'b1) begin bad++; $display("FAIL chk_recover_we got=%b exp=1", bus.cfg_we); end
    total++; if ({bus.cfg_sel, bus.cfg_data} !== {2'b00, 8'h02}) begin bad++; $display("FAIL chk_recover_cfg got=%b/%h exp=00/02", bus.cfg_sel, bus.cfg_data); end
`ifdef SPI_FRAMER_CHKSUM_EN
    total++; if (bus.status_byte !== 8'h01) begin bad++; $display("FAIL chk_recover_status got=%h exp=01", bus.status_byte); end
`else
    total++; if (bus.status_byte !== 8'h02) begin bad++; $display("FAIL chk_recover_status got=%h exp=02", bus.status_byte); end
`endif
  endtask

  task automatic test_hdr_read();
    int we0, rd0;
    do_reset();
    send_byte(8'h3C);
    total++; if (bus.status_byte !== 8'h20) begin bad++; $display("FAIL hdr_status got=%h exp=20", bus.status_byte); end
    total++; if (bus.err_cnt !== 8'd1) begin bad++; $display("FAIL hdr_errcnt got=%0d exp=1", bus.err_cnt); end
    tick();
    we0 = we_cnt; rd0 = rd_cnt;
    send_frame(8'hC0, 8'h00);
    total++; if (bus.rd_strobe !== 1'b1) begin bad++; $display("FAIL rd_strobe got=%b exp=1", bus.rd_strobe); end
    total++; if (bus.cfg_we !== 1'b0) begin bad++; $display("FAIL rd_we got=%b exp=0", bus.cfg_we); end
    total++; if (bus.status_byte !== 8'h01) begin bad++; $display("FAIL rd_status got=%h exp=01", bus.status_byte); end
    total++; if ({bus.cfg_sel, bus.cfg_data} !== 10'd0) begin bad++; $display("FAIL rd_cfg_hold got=%b/%h exp=00/00", bus.cfg_sel, bus.cfg_data); end
    tick();
    total++; if (rd_cnt != rd0 + 1 || we_cnt != we0) begin bad++; $display("FAIL rd_counts got=rd%0d/we%0d exp=rd%0d/we%0d", rd_cnt, we_cnt, rd0 + 1, we0); end
  endtask

  task automatic test_abort();
    int we0;
    do_reset();
    we0 = we_cnt;
    send_byte(8'hA5); send_byte(8'h80);
    total++; if (bus.status_byte !== 8'h80) begin bad++; $display("FAIL abort_busy got=%h exp=80", bus.status_byte); end
    bus.ss_active = 1'b0;
    tick();
    bus.ss_active = 1'b1;
    total++; if (bus.status_byte !== 8'h60) begin bad++; $display("FAIL abort_ss_status got=%h exp=60", bus.status_byte); end
    total++; if (bus.err_cnt !== 8'd1) begin bad++; $display("FAIL abort_ss_errcnt got=%0d exp=1", bus.err_cnt); end
    send_byte(8'hA5);
    bus.ss_active = 1'b0;
    send_byte(8'h40);
    total++; if (bus.status_byte !== 8'h60 || bus.err_cnt !== 8'd2) begin bad++; $display("FAIL abort_simul got=%h/%0d exp=60/2", bus.status_byte, bus.err_cnt); end
    send_byte(8'h3C);
    total++; if (bus.status_byte !== 8'h60 || bus.err_cnt !== 8'd2) begin bad++; $display("FAIL idle_ss_low got=%h/%0d exp=60/2", bus.status_byte, bus.err_cnt); end
    bus.ss_active = 1'b1;
    tick();
    total++; if (we_cnt != we0) begin bad++; $display("FAIL abort_nostrobe got=%0d exp=%0d", we_cnt, we0); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'hA5);
    repeat (TO - 1) tick();
    total++; if (bus.status_byte !== 8'h80) begin bad++; $display("FAIL to_early got=%h exp=80", bus.status_byte); end
    tick();
    total++; if (bus.status_byte !== 8'h60 || bus.err_cnt !== 8'd1) begin bad++; $display("FAIL to_fire got=%h/%0d exp=60/1", bus.status_byte, bus.err_cnt); end
    send_byte(8'hA5);
    repeat (TO - 3) tick();
    send_byte(8'h40);
    repeat (TO - 2) tick();
    total++; if (bus.status_byte !== 8'hE0) begin bad++; $display("FAIL to_rearm got=%h exp=E0", bus.status_byte); end
    send_byte(8'h00);
`ifdef SPI_FRAMER_CHKSUM_EN
    send_byte(8'hE5);
`endif
    total++; if (bus.cfg_we !== 1'b1 || bus.status_byte !== 8'h01) begin bad++; $display("FAIL to_commit got=%b/%h exp=1/01", bus.cfg_we, bus.status_byte); end
  endtask

  task automatic test_back_to_back();
    int we0, rd0;
    do_reset();
    we0 = we_cnt; rd0 = rd_cnt;
    send_frame(8'h00, 8'h01);
    send_frame(8'h80, 8'h02);
    send_frame(8'hC0, 8'h00);
    tick();
    total++; if ({bus.cfg_sel, bus.cfg_data} !== {2'b10, 8'h02}) begin bad++; $display("FAIL b2b_cfg got=%b/%h exp=10/02", bus.cfg_sel, bus.cfg_data); end
    total++; if (bus.status_byte !== 8'h03) begin bad++; $display("FAIL b2b_status got=%h exp=03", bus.status_byte); end
    total++; if (we_cnt != we0 + 2 || rd_cnt != rd0 + 1) begin bad++; $display("FAIL b2b_counts got=we%0d/rd%0d exp=we%0d/rd%0d", we_cnt, rd_cnt, we0 + 2, rd0 + 1); end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (254) send_byte(8'h00);
    total++; if (bus.err_cnt !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d exp=254", bus.err_cnt); end
    repeat (46) send_byte(8'h00);
    total++; if (bus.err_cnt !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d exp=255", bus.err_cnt); end
    total++; if (bus.status_byte !== 8'h20) begin bad++; $display("FAIL sat_status got=%h exp=20", bus.status_byte); end
    repeat (33) send_frame(8'h40, 8'h01);
    total++; if (bus.status_byte !== 8'h01) begin bad++; $display("FAIL wrap_status got=%h exp=01", bus.status_byte); end
    total++; if (bus.err_cnt !== 8'd255) begin bad++; $display("FAIL wrap_errcnt got=%0d exp=255", bus.err_cnt); end
  endtask

  task automatic test_reset_midframe();
    int we0, rd0;
    do_reset();
    send_byte(8'hA5); send_byte(8'h40);
    we0 = we_cnt; rd0 = rd_cnt;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    total++; if (bus.status_byte !== 8'h00 || bus.err_cnt !== 8'h00 || bus.cfg_we !== 1'b0) begin bad++; $display("FAIL mid_reset got=%h/%h/%b exp=00/00/0", bus.status_byte, bus.err_cnt, bus.cfg_we); end
    send_byte(8'h03); send_byte(8'hE6);
    tick();
    total++; if (bus.status_byte !== 8'h20 || bus.err_cnt !== 8'd2) begin bad++; $display("FAIL mid_stray got=%h/%0d exp=20/2", bus.status_byte, bus.err_cnt); end
    total++; if (we_cnt != we0 || rd_cnt != rd0) begin bad++; $display("FAIL mid_nostrobe got=we%0d/rd%0d exp=we%0d/rd%0d", we_cnt, rd_cnt, we0, rd0); end
  endtask

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_byte   = 8'h00;
    bus.ss_active = 1'b0;
    test_reset();
    test_write();
    test_bad_chk();
    test_hdr_read();
    test_abort();
    test_timeout();
    test_back_to_back();
    test_saturation();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_framer.md
# spi_cmd_framer

Packet-level command framer that sits directly downstream of the SPI slave byte receiver and upstream of the configuration registers (function select, input A, input B). It assembles raw received bytes into checksummed frames, rejects malformed or aborted frames, and issues one-cycle configuration write or read strobes. It also exports a status byte for the MISO transmit path, so the Arduino master can confirm frame delivery.

## Interface
- `TIMEOUT_CYCLES`, default 50000: maximum idle clk cycles between bytes inside a frame (1 ms at 50 MHz).
- `clk`  in  1  50 MHz system clock.
- `reset_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `rx_valid`  in  1  one-cycle strobe: `rx_byte` is a complete received byte.
- `rx_byte`  in  8  received byte, MSB first as shifted in.
- `ss_active`  in  1  synchronized slave-select, high while a transaction is in progress.
- `cfg_we`  out  1  one-cycle configuration write strobe.
- `cfg_sel`  out  2  target: 00 function, 01 input A, 10 input B.
- `cfg_data`  out  8  write payload; the consumer uses bits [1:0].
- `rd_strobe`  out  1  one-cycle pulse for a valid read frame (op 11).
- `status_byte`  out  8  {busy, last_err[1:0], frame_cnt[4:0]}.
- `err_cnt`  out  8  saturating count of rejected frames.

## Operation
- Frame format: HDR (0xA5), CMD, DATA, CHK. CMD[7:6] is the op; CMD[5:0] is ignored. CHK = HDR ^ CMD ^ DATA.
- FSM states and transitions:
  - IDLE: `rx_valid` with byte = 0xA5 → CMD. Any other byte → stay in IDLE and log error 01.
  - CMD: `rx_valid` → latch CMD, go to DATA.
  - DATA: `rx_valid` → latch DATA, go to CHK.
  - CHK: `rx_valid` with a matching checksum → commit, go to IDLE. On a mismatch, log error 10 and go to IDLE.
- Commit behaviour:
  - Op 00/01/10: pulse `cfg_we` with `cfg_sel` = op and `cfg_data` = DATA.
  - Op 11: pulse `rd_strobe` only.
  - Both cases increment `frame_cnt` (5-bit, wraps 31→0).
- Abort: in any state other than IDLE, `ss_active` low or a timeout logs error 11 and returns to IDLE. `ss_active` low while in IDLE is not an error.
- Error logging:
  - `last_err` takes the new code.
  - `err_cnt` increments and saturates at 255.
  - `last_err` is cleared to 00 on a successful commit. `err_cnt` is never cleared except by reset.
- `busy` is high in every state except IDLE.
- Simultaneous `rx_valid` and `ss_active` low: abort wins and the byte is discarded. In IDLE, the byte is discarded silently.
- Timeout counter:
  - Clears on every `rx_valid` and whenever the FSM is in IDLE.
  - Counts in all other states.
  - Reaching TIMEOUT_CYCLES−1 aborts the frame.
  - Counter width is $clog2(TIMEOUT_CYCLES).

## Timing
- Reset values: `cfg_we` 0, `rd_strobe` 0, `cfg_sel` 00, `cfg_data` 0x00, `status_byte` 0x00, `err_cnt` 0x00. FSM goes to IDLE and the timer to 0.
- Reset asserted mid-frame discards the partial frame with no strobe on the next edge.
- `cfg_we` / `rd_strobe` assert on the clk edge following the final byte's `rx_valid`, and last exactly one cycle.
- `cfg_sel` and `cfg_data` are registered. They are valid in the strobe cycle and hold until the next commit.
- `status_byte` and `err_cnt` update on the same edge as the commit or the error.
- Back-to-back frames are supported. A header byte arriving in the cycle immediately after a commit is accepted.

## Configuration
- `SPI_FRAMER_CHKSUM_EN`:
  - Defined: 4-byte frame with the CHK state as described; error 10 is possible.
  - Undefined: 3-byte frame (HDR, CMD, DATA). DATA commits directly, the CHK state and checksum logic are not compiled, and error 10 never occurs.

## Structure
- Shared package `spi_framer_pkg` holds:
  - the header constant 0xA5;
  - error codes ERR_NONE 00, ERR_HDR 01, ERR_CHK 10, ERR_ABORT 11;
  - op codes OP_FUNC, OP_A, OP_B, OP_RD;
  - the FSM state enumeration.
- Sub-module `spi_frame_timer` contains the clearable timeout counter. Inputs: `clk`, `reset_n`, `clr`, `en`. Output: one-cycle `expired`.

## Test plan
- Normal write: A5 40 03 E6 → one `cfg_we`, `cfg_sel` = 01, `cfg_data` = 0x03, `frame_cnt` = 1, `last_err` = 00.
- Bad checksum: A5 40 03 00 → no strobe, `last_err` = 10, `err_cnt` = 1. Then A5 00 02 A7 → `cfg_we`, `cfg_sel` = 00, `last_err` = 00.
- Bad header and read: 3C, then A5 C0 00 65 → `err_cnt` = 1, `last_err` = 00, `rd_strobe` pulses, `cfg_we` stays 0.
- Abort: A5 80, then `ss_active` low; separately, A5 then TIMEOUT_CYCLES idle cycles → each gives `last_err` = 11 and `err_cnt` +1, with no strobe.
- Saturation and wrap: 300 bad frames → `err_cnt` = 255. 33 good frames → `frame_cnt` = 1.
- Reset mid-frame: A5 40, `reset_n` low for one cycle, then 03 E6 → no strobe, all outputs 0; errors from stray bytes are logged.
